// File: rtl/instr_fetch_decode.sv
// Fetch/decode stage feeding ctrl_unit: Z register, EXTEND/INDEX handling, field split.
// Optional saturating fetch counter enabled by IFD_FETCH_COUNT_EN.
module instr_fetch_decode #(
    parameter logic [11:0] RESET_ADDR  = 12'o4000,
    parameter logic [14:0] EXTEND_WORD = 15'o00006
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        mem_rd_req,
    output logic [11:0] mem_rd_addr,
    input  logic        mem_rd_ack,
    input  logic [14:0] mem_rd_data,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [2:0]  Op,
    output logic [1:0]  QC,
    output logic        PC,
    output logic [11:0] Addr12,
    output logic [9:0]  Addr10,
    output logic        extracode,
    output logic [14:0] instr_word,
    output logic [11:0] instr_addr,
    input  logic        redirect_valid,
    input  logic [11:0] redirect_addr,
    input  logic        index_valid,
    input  logic [14:0] index_value,
    output logic [15:0] fetch_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_HOLD
    } state_t;

    state_t      state_q;
    logic [11:0] z_q;
    logic        extend_q;
    logic        index_pend_q;
    logic [14:0] idx_q;
    logic        discard_q;
    logic [14:0] word_q;
    logic [11:0] addr_q;
    logic        extra_q;

    logic [14:0] word_d;
    logic        take_ack;
    logic        is_ext;
    logic        ext_index;

    function automatic logic [14:0] oc_add(input logic [14:0] a, input logic [14:0] b);
        logic [15:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[14:0] + {14'd0, s[15]};
    endfunction

    always_comb begin
        word_d    = index_pend_q ? oc_add(mem_rd_data, idx_q) : mem_rd_data;
        take_ack  = (state_q == S_FETCH) && mem_rd_ack && !discard_q && !redirect_valid;
        is_ext    = (word_d == EXTEND_WORD) && !extend_q;
        ext_index = extra_q && (word_q[14:12] == 3'b101) && (word_q[11:10] == 2'b00);
    end

    // Later assignments in the block override earlier ones: redirect, then index.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            z_q          <= RESET_ADDR;
            extend_q     <= 1'b0;
            index_pend_q <= 1'b0;
            idx_q        <= '0;
            discard_q    <= 1'b0;
            word_q       <= '0;
            addr_q       <= '0;
            extra_q      <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: state_q <= S_FETCH;
                S_FETCH: begin
                    if (mem_rd_ack) begin
                        discard_q <= 1'b0;
                    end
                    if (take_ack) begin
                        index_pend_q <= 1'b0;
                        z_q          <= z_q + 12'd1;
                        if (is_ext) begin
                            extend_q <= 1'b1;
                        end else begin
                            word_q  <= word_d;
                            addr_q  <= z_q;
                            extra_q <= extend_q;
                            state_q <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (dec_ready) begin
                        state_q <= S_FETCH;
                        if (!ext_index) extend_q <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
            if (redirect_valid) begin
                z_q          <= redirect_addr;
                extend_q     <= 1'b0;
                index_pend_q <= 1'b0;
                // Outstanding request still gets its ack; that data is stale.
                if (state_q == S_FETCH && !mem_rd_ack) discard_q <= 1'b1;
                if (state_q == S_HOLD) state_q <= S_FETCH;
            end
            if (index_valid) begin
                idx_q        <= index_value;
                index_pend_q <= 1'b1;
            end
        end
    end

    assign mem_rd_req  = (state_q == S_FETCH);
    assign mem_rd_addr = mem_rd_req ? z_q : 12'd0;
    assign dec_valid   = (state_q == S_HOLD);
    assign Op          = word_q[14:12];
    assign QC          = word_q[11:10];
    assign PC          = word_q[9];
    assign Addr12      = word_q[11:0];
    assign Addr10      = word_q[9:0];
    assign extracode   = extra_q;
    assign instr_word  = word_q;
    assign instr_addr  = addr_q;

`ifdef IFD_FETCH_COUNT_EN
    logic [15:0] fcnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fcnt_q <= '0;
        end else if (take_ack && fcnt_q != 16'hFFFF) begin
            fcnt_q <= fcnt_q + 16'd1;
        end
    end

    assign fetch_count = fcnt_q;
`else
    assign fetch_count = 16'd0;
`endif

endmodule
